// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//   Holds and counts down the mm:ss cook time shown on the display. Keypad
//   digits shift in from the right while idle (1,3,0 -> 1:30). Start, stop
//   and clear control a once-per-second countdown derived from clk.
//
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   digit_valid  in   one-cycle strobe, keypad digit present
//   digit        in   keypad value, only 0..9 accepted
//   start        in   one-cycle strobe, start or resume countdown
//   stop         in   one-cycle strobe, pause countdown
//   clear        in   one-cycle strobe, zero the time and return to idle
//   mins         out  BCD minutes 0..9
//   sec_tens     out  BCD tens of seconds 0..5
//   sec_ones     out  BCD units of seconds 0..9
//   running      out  high while counting
//   done         out  one-cycle pulse when the count reaches 0:00
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | time entry; start accepted only when time is non-zero
//   ST_RUN    | prescaler advancing, time decrements at terminal count
//   ST_PAUSED | time and prescaler frozen until start
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  localparam int unsigned PRE_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PRE_W-1:0] pre, pre_nxt;
  logic [3:0]       mins_nxt, tens_nxt, ones_nxt;
  logic             hit_zero;
  logic             running_nxt, done_nxt;
  logic             time_zero;
  logic             digit_ok;

  assign time_zero = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  // Shifting is refused once the minutes slot is occupied, and also when the
  // current units digit would land in the tens slot as a value above 5.
  assign digit_ok  = (digit <= 4'd9) && (mins == 4'd0) && (sec_ones <= 4'd5);

  // state register plus the time/prescaler datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pre      <= '0;
      mins     <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pre      <= pre_nxt;
      mins     <= mins_nxt;
      sec_tens <= tens_nxt;
      sec_ones <= ones_nxt;
      running  <= running_nxt;
      done     <= done_nxt;
    end
  end

  // next-state and datapath; priority clear > stop > start > digit_valid
  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    mins_nxt  = mins;
    tens_nxt  = sec_tens;
    ones_nxt  = sec_ones;
    hit_zero  = 1'b0;

    if (clear) begin
      state_nxt = ST_IDLE;
      pre_nxt   = '0;
      mins_nxt  = 4'd0;
      tens_nxt  = 4'd0;
      ones_nxt  = 4'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (stop) begin
            // ignored, but still outranks start and digit entry
          end else if (start) begin
            if (!time_zero) begin
              state_nxt = ST_RUN;
              pre_nxt   = '0;
            end
          end else if (digit_valid && digit_ok) begin
            mins_nxt = sec_tens;
            tens_nxt = sec_ones;
            ones_nxt = digit;
          end
        end

        ST_RUN: begin
          if (stop) begin
            // a rollover due this cycle stays pending in the held prescaler
            state_nxt = ST_PAUSED;
          end else if (pre == PRE_TC) begin
            pre_nxt = '0;
            if (sec_ones != 4'd0) begin
              ones_nxt = sec_ones - 4'd1;
            end else begin
              ones_nxt = 4'd9;
              if (sec_tens != 4'd0) begin
                tens_nxt = sec_tens - 4'd1;
              end else begin
                tens_nxt = 4'd5;
                mins_nxt = mins - 4'd1;
              end
            end
            // RUN is never entered at 0:00, so 0:01 is the only path to zero
            if ((mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1)) begin
              hit_zero  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else begin
            pre_nxt = pre + 1'b1;
          end
        end

        ST_PAUSED: begin
          if (!stop && start) begin
            state_nxt = ST_RUN;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // registered outputs are loaded from their next values
  always_comb begin
    running_nxt = (state_nxt == ST_RUN);
    done_nxt    = hit_zero;
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] mins;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;

  logic [11:0] tm;
  assign tm = {mins, sec_tens, sec_ones};

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt;

  bcd_countdown_timer #(.TICKS_PER_SEC(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .mins        (mins),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance n rising edges, then sit 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s_start, input logic s_stop, input logic s_clear,
                       input logic s_dv, input logic [3:0] d);
    start       = s_start;
    stop        = s_stop;
    clear       = s_clear;
    digit_valid = s_dv;
    digit       = d;
    tick(1);
    start       = 1'b0;
    stop        = 1'b0;
    clear       = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
  endtask

  task automatic key(input logic [3:0] d);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic do_start();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_stop();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_clear();
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    rst_n = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    #1;
    check("rst_time", 32'(tm), 32'h000);
    check("rst_running", 32'(running), 0);
    check("rst_done", 32'(done), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // digit entry
    key(4'd1); key(4'd3); key(4'd0);
    check("entry_130", 32'(tm), 32'h130);
    key(4'd7);
    check("entry_full", 32'(tm), 32'h130);
    key(4'd12);
    check("entry_12_full", 32'(tm), 32'h130);
    do_clear();
    key(4'd12);
    check("entry_12_empty", 32'(tm), 32'h000);
    key(4'd7); key(4'd8);
    check("entry_78", 32'(tm), 32'h007);
    do_clear();
    check("clear_time", 32'(tm), 32'h000);
    check("clear_running", 32'(running), 0);

    // 1:00 full countdown; start edge is edge 0
    key(4'd1); key(4'd0); key(4'd0);
    check("entry_100", 32'(tm), 32'h100);
    do_start();
    check("run_running", 32'(running), 1);
    tick(3);
    check("run_edge3", 32'(tm), 32'h100);
    tick(1);
    check("run_edge4", 32'(tm), 32'h059);
    tick(4);
    check("run_edge8", 32'(tm), 32'h058);
    done_cnt = 0;
    for (int i = 9; i <= 239; i++) begin
      tick(1);
      if (done) done_cnt++;
    end
    check("run_edge239", 32'(tm), 32'h001);
    check("run_early_done", 32'(done_cnt), 0);
    tick(1);
    check("run_edge240_time", 32'(tm), 32'h000);
    check("run_edge240_done", 32'(done), 1);
    check("run_edge240_running", 32'(running), 0);
    tick(1);
    check("run_done_pulse", 32'(done), 0);

    // 0:05 with pause: stop is sampled on the 7th edge after start (prescaler=2)
    key(4'd5);
    check("entry_005", 32'(tm), 32'h005);
    do_start();
    tick(4);
    check("p_edge4", 32'(tm), 32'h004);
    tick(2);
    do_stop();
    check("p_stop_running", 32'(running), 0);
    tick(20);
    check("p_hold_time", 32'(tm), 32'h004);
    check("p_hold_running", 32'(running), 0);
    do_start();
    check("p_resume_running", 32'(running), 1);
    tick(1);
    check("p_resume_1", 32'(tm), 32'h004);
    tick(1);
    check("p_resume_2", 32'(tm), 32'h003);
    tick(3);
    check("p_resume_5", 32'(tm), 32'h003);
    tick(1);
    check("p_resume_6", 32'(tm), 32'h002);
    // stop exactly at terminal count: decrement suppressed, fires after resume
    tick(3);
    check("tc_before_stop", 32'(tm), 32'h002);
    do_stop();
    check("tc_suppressed", 32'(tm), 32'h002);
    do_start();
    check("tc_resume_edge", 32'(tm), 32'h002);
    tick(1);
    check("tc_fires", 32'(tm), 32'h001);
    tick(3);
    check("tc_last_time", 32'(tm), 32'h001);
    check("tc_last_done", 32'(done), 0);
    tick(1);
    check("tc_zero_time", 32'(tm), 32'h000);
    check("tc_zero_done", 32'(done), 1);
    check("tc_zero_running", 32'(running), 0);

    // start at 0:00 is ignored
    do_start();
    check("zs_running", 32'(running), 0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (done || running) done_cnt++;
    end
    check("zs_quiet", 32'(done_cnt), 0);

    // stop+start together in RUN pauses; digits ignored while paused
    key(4'd9);
    do_start();
    tick(1);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("ss_running", 32'(running), 0);
    tick(8);
    check("ss_hold", 32'(tm), 32'h009);
    key(4'd3);
    check("ss_digit_ignored", 32'(tm), 32'h009);
    do_clear();
    check("ss_clear", 32'(tm), 32'h000);

    // asynchronous reset between edges while running
    key(4'd4);
    do_start();
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_time", 32'(tm), 32'h000);
    check("ar_running", 32'(running), 0);
    check("ar_done", 32'(done), 0);
    tick(1);
    rst_n = 1'b1;
    do_start();
    check("ar_start_ignored", 32'(running), 0);
    tick(5);
    check("ar_still_zero", 32'(tm), 32'h000);
    key(4'd2);
    do_start();
    check("ar_start_ok", 32'(running), 1);
    check("ar_start_time", 32'(tm), 32'h002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
